// File: rtl/if_fetch_align_pkg.sv
// Shared fetch-stage constants and the RVC length decode helper.
// Queue depth, PC width and reset PC live here so the interface and all stages agree.
package fetch_pkg;

    localparam int              PC_W         = 12;
    localparam int              QDEPTH       = 4;
    localparam logic [PC_W-1:0] DEF_RESET_PC = 12'h000;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_fetch_align_if.sv
// Fetch stage boundary: INSTMEM request/return, redirect/stall from the pipeline, aligned instruction out.
// master = fetch stage, slave = surrounding pipeline/memory.
interface if_fetch_align_if;
    import fetch_pkg::*;

    logic [PC_W-3:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            id_stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            if_valid;
    logic [31:0]     if_inst;
    logic [PC_W-1:0] if_PC;
    logic [PC_W-1:0] if_pc4;
    logic            if_is_c;

    modport master (
        output imem_addr, if_valid, if_inst, if_PC, if_pc4, if_is_c,
        input  imem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, if_valid, if_inst, if_PC, if_pc4, if_is_c,
        output imem_rdata, id_stall, redirect, redirect_pc
    );

endinterface

// File: rtl/if_fetch_align_hw_queue.sv
// 4x16 halfword shift queue; pushes and pops 0..2 halfwords per cycle, flush empties it.
// Registered state, q0/q1/cnt visible the cycle after update; caller must not overfill.
module fetch_hw_queue
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  push_n,
    input  logic [15:0] push_lo,
    input  logic [15:0] push_hi,
    input  logic [1:0]  pop_n,
    output logic [15:0] q0,
    output logic [15:0] q1,
    output logic [2:0]  cnt
);

    logic [QDEPTH-1:0][15:0] q;
    logic [QDEPTH-1:0][15:0] q_sh;
    logic [QDEPTH-1:0][15:0] q_nxt;
    logic [2:0]              base;
    logic [2:0]              cnt_nxt;

    always_comb begin
        q_sh    = q >> {pop_n, 4'b0000};
        base    = cnt - {1'b0, pop_n};
        q_nxt   = q_sh;
        // New halfwords land just behind whatever survives the pop.
        for (int i = 0; i < QDEPTH; i++) begin
            if (push_n != 2'd0 && 3'(i) == base)
                q_nxt[i] = push_lo;
            if (push_n == 2'd2 && 3'(i) == base + 3'd1)
                q_nxt[i] = push_hi;
        end
        cnt_nxt = flush ? 3'd0 : base + {1'b0, push_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            cnt <= 3'd0;
        end else begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign q0 = q[0];
    assign q1 = q[1];

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        ({1'b0, pop_n} <= cnt));
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (flush || ({1'b0, base} + {2'b0, push_n} <= 4'(QDEPTH))));

endmodule

// File: rtl/if_fetch_align.sv
// PC generation + INSTMEM fetch + RVC realignment; first instruction 2 cycles after reset/redirect.
// id_stall freezes the head but the queue keeps absorbing returns; redirect flushes and refetches.
module if_fetch_align
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_align_if.master   fif
);

    localparam int FW = PC_W - 2;

    logic [PC_W-1:0] pc;
    logic [FW-1:0]   fptr;
    logic            infl;
    logic            drop_lo;

    logic [15:0] q0, q1;
    logic [2:0]  cnt;
    logic        head_c;
    logic        vld;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [15:0] push_lo, push_hi;
    logic [3:0]  occ;
    logic        req;

    fetch_hw_queue u_q (
        .clk     (clk),
        .rst     (rst),
        .flush   (fif.redirect),
        .push_n  (push_n),
        .push_lo (push_lo),
        .push_hi (push_hi),
        .pop_n   (pop_n),
        .q0      (q0),
        .q1      (q1),
        .cnt     (cnt)
    );

    always_comb begin
        head_c = is_compressed(q0);
        vld    = head_c ? (cnt >= 3'd1) : (cnt >= 3'd2);

        pop_n = 2'd0;
        if (vld && !fif.id_stall && !fif.redirect)
            pop_n = head_c ? 2'd1 : 2'd2;

        push_n  = 2'd0;
        push_lo = fif.imem_rdata[15:0];
        push_hi = fif.imem_rdata[31:16];
        if (infl && !fif.redirect) begin
            if (drop_lo) begin
                push_n  = 2'd1;
                push_lo = fif.imem_rdata[31:16];
            end else begin
                push_n  = 2'd2;
            end
        end

        // Only fetch when the word (plus any already in flight) is guaranteed to fit.
        occ = {1'b0, cnt} - {2'b0, pop_n} + (infl ? 4'd2 : 4'd0);
        req = occ <= 4'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            fptr    <= RESET_PC[PC_W-1:2];
            infl    <= 1'b0;
            drop_lo <= RESET_PC[1];
        end else if (fif.redirect) begin
            pc      <= {fif.redirect_pc[PC_W-1:1], 1'b0};
            fptr    <= fif.redirect_pc[PC_W-1:2] + FW'(1);
            infl    <= 1'b1;
            drop_lo <= fif.redirect_pc[1];
        end else begin
            pc   <= pc + PC_W'({pop_n, 1'b0});
            infl <= req;
            if (req)
                fptr <= fptr + FW'(1);
            if (infl)
                drop_lo <= 1'b0;
        end
    end

    always_comb begin
        fif.imem_addr = fif.redirect ? fif.redirect_pc[PC_W-1:2] : fptr;
        fif.if_valid  = vld;
        fif.if_inst   = '0;
        fif.if_PC     = '0;
        fif.if_pc4    = '0;
        fif.if_is_c   = 1'b0;
        if (vld) begin
            fif.if_inst = head_c ? {16'h0000, q0} : {q1, q0};
            fif.if_PC   = pc;
            fif.if_pc4  = pc + (head_c ? PC_W'(2) : PC_W'(4));
            fif.if_is_c = head_c;
        end
    end

endmodule

// File: tb/tb_if_fetch_align.sv
// Directed bench: hand-timed program stream through stall, redirect, PC wrap and async reset.
module tb_if_fetch_align;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [1024];

    if_fetch_align_if fif();

    if_fetch_align #(.RESET_PC(12'h000)) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) fif.imem_rdata <= mem[fif.imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] inst,
                           input logic [11:0] pc, input logic [11:0] pc4, input logic c);
        chk({tag, "_valid"}, {31'd0, fif.if_valid}, {31'd0, v});
        chk({tag, "_inst"},  fif.if_inst, inst);
        chk({tag, "_pc"},    {20'd0, fif.if_PC}, {20'd0, pc});
        chk({tag, "_pc4"},   {20'd0, fif.if_pc4}, {20'd0, pc4});
        chk({tag, "_is_c"},  {31'd0, fif.if_is_c}, {31'd0, c});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]     = 32'h00A00093;
        mem[1]     = 32'h45054501;
        mem[2]     = 32'h00934585;
        mem[3]     = 32'h000100A0;
        mem[4]     = 32'h45050001;
        mem[5]     = 32'h00A00093;
        mem[6]     = 32'h45854501;
        mem[10'h3FF] = 32'h00050000;

        rst             = 1'b1;
        fif.id_stall    = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 12'h000;
        step();
        step();
        chk_out("reset", 1'b0, 32'h0, 12'h000, 12'h000, 1'b0);

        rst = 1'b0;
        #1;
        chk("c0_addr", {22'd0, fif.imem_addr}, 32'd0);
        step();
        chk("c1_valid", {31'd0, fif.if_valid}, 32'd0);
        chk("c1_addr", {22'd0, fif.imem_addr}, 32'd1);
        step(); chk_out("c2", 1'b1, 32'h00A00093, 12'h000, 12'h004, 1'b0);
        step(); chk_out("c3", 1'b1, 32'h00004501, 12'h004, 12'h006, 1'b1);
        step(); chk_out("c4", 1'b1, 32'h00004505, 12'h006, 12'h008, 1'b1);
        step(); chk_out("c5", 1'b1, 32'h00004585, 12'h008, 12'h00A, 1'b1);
        step(); chk_out("c6_straddle", 1'b1, 32'h00A00093, 12'h00A, 12'h00E, 1'b0);
        step(); chk_out("c7", 1'b1, 32'h00000001, 12'h00E, 12'h010, 1'b1);

        // Three stall cycles: head must hold, queue fills to 4.
        step();
        fif.id_stall = 1'b1;
        #1 chk_out("stall0", 1'b1, 32'h00000001, 12'h010, 12'h012, 1'b1);
        step(); chk_out("stall1", 1'b1, 32'h00000001, 12'h010, 12'h012, 1'b1);
        chk("stall1_cnt", {29'd0, dut.u_q.cnt}, 32'd4);
        step(); chk_out("stall2", 1'b1, 32'h00000001, 12'h010, 12'h012, 1'b1);
        chk("stall2_cnt", {29'd0, dut.u_q.cnt}, 32'd4);
        step();
        fif.id_stall = 1'b0;
        #1 chk_out("c11", 1'b1, 32'h00000001, 12'h010, 12'h012, 1'b1);
        step(); chk_out("c12", 1'b1, 32'h00004505, 12'h012, 12'h014, 1'b1);
        step(); chk_out("c13", 1'b1, 32'h00A00093, 12'h014, 12'h018, 1'b0);

        // Redirect to 0x012 while stalled; word 6 in flight must be discarded.
        fif.id_stall    = 1'b1;
        fif.redirect    = 1'b1;
        fif.redirect_pc = 12'h012;
        #1 chk("redir_addr", {22'd0, fif.imem_addr}, 32'd4);
        step();
        fif.redirect = 1'b0;
        fif.id_stall = 1'b0;
        #1 chk("c14_valid", {31'd0, fif.if_valid}, 32'd0);
        chk("c14_addr", {22'd0, fif.imem_addr}, 32'd5);
        step(); chk_out("c15_redir", 1'b1, 32'h00004505, 12'h012, 12'h014, 1'b1);
        step(); chk_out("c16", 1'b1, 32'h00A00093, 12'h014, 12'h018, 1'b0);

        // Redirect to the last halfword: pc4 and fetch pointer wrap to 0.
        fif.redirect    = 1'b1;
        fif.redirect_pc = 12'hFFE;
        #1 chk("wrap_addr", {22'd0, fif.imem_addr}, 32'h3FF);
        step();
        fif.redirect = 1'b0;
        #1 chk("c17_valid", {31'd0, fif.if_valid}, 32'd0);
        step(); chk_out("c18_wrap", 1'b1, 32'h00000005, 12'hFFE, 12'h000, 1'b1);
        step(); chk_out("c19", 1'b1, 32'h00A00093, 12'h000, 12'h004, 1'b0);
        chk("c19_infl", {31'd0, dut.infl}, 32'd1);

        // Async reset pulse mid-cycle with a request outstanding.
        #2 rst = 1'b1;
        #1 chk_out("arst", 1'b0, 32'h0, 12'h000, 12'h000, 1'b0);
        #2 rst = 1'b0;
        step();
        chk("c20_valid", {31'd0, fif.if_valid}, 32'd0);
        step(); chk_out("c21", 1'b1, 32'h00A00093, 12'h000, 12'h004, 1'b0);
        step(); chk_out("c22", 1'b1, 32'h00004501, 12'h004, 12'h006, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_align.md
Name: if_fetch_align

Overview:
- PC generation and instruction-fetch stage for the RV32IMC pipeline; its outputs feed the if_id pipeline register directly.
- Issues word addresses to the synchronous-read INSTMEM and buffers returned halfwords in a 4-entry queue.
- Delivers one aligned instruction per cycle (16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary), together with its PC and next-sequential PC.
- Handles downstream stall and branch/jump redirect.

Parameters:
- PC_W, 12, byte-address width of PC (4 KB INSTMEM).
- RESET_PC, 12'h000, PC after reset (bit 0 must be 0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_addr  out  PC_W-2  word address to INSTMEM; read data returns next cycle.
- imem_rdata  in  32  INSTMEM read data for the address presented in the previous cycle.
- id_stall  in  1  downstream not accepting; hold current output.
- redirect  in  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  in  PC_W  redirect target; bit 0 ignored.
- if_valid  out  1  if_inst/if_PC/if_pc4 hold a real instruction.
- if_inst  out  32  instruction; compressed ones in [15:0] with [31:16]=0.
- if_PC  out  PC_W  PC of if_inst.
- if_pc4  out  PC_W  next sequential PC (if_PC+2 if compressed, else +4).
- if_is_c  out  1  if_inst is compressed (low bits != 2'b11).

Behaviour:
- State:
  - pc: PC of queue head.
  - fptr: next word to request.
  - q: 4×16-bit halfwords.
  - cnt: 0..4.
  - infl: request outstanding, data arrives this cycle.
  - drop_lo: discard low halfword of the arriving word.
- Reset (async, any time, including mid-redirect):
  - pc=RESET_PC, fptr=RESET_PC[PC_W-1:2], cnt=0, infl=0, drop_lo=RESET_PC[1].
  - if_valid=0, if_inst=0, if_PC=0, if_pc4=0, if_is_c=0.
- Output (combinational from queue head):
  - Compressed head: valid when cnt>=1.
  - 32-bit head: valid when cnt>=2; the high half is q[1].
  - When not valid, if_inst/if_PC/if_pc4/if_is_c are driven 0.
- pop:
  - 0 if id_stall or !if_valid.
  - Otherwise 1 (compressed) or 2 (32-bit).
  - pc advances by 2×pop, mod 2^PC_W (0xFFE+2 wraps to 0x000).
- push:
  - If infl: push imem_rdata[31:16] only when drop_lo, else [15:0] then [31:16].
  - drop_lo clears on that push.
- Request rule:
  - req = (cnt - pop + (infl ? 2 : 0)) <= 2.
  - On req, next infl=1 and fptr+=1 (wraps at 2^(PC_W-2)).
  - Invariant: cnt never exceeds 4. A push arriving with cnt-pop>2 is a design error (assertion).
- Addressing: imem_addr = redirect ? redirect_pc[PC_W-1:2] : fptr.
- Throughput: steady state is one instruction per cycle for all-32-bit, all-compressed and mixed streams.
- Latency: first valid instruction 2 cycles after reset deassertion or after the redirect cycle.
- Redirect (highest priority, overrides id_stall in the same cycle):
  - cnt=0.
  - The current-cycle pop is void.
  - Any in-flight data is discarded.
  - pc=redirect_pc&~1.
  - Target word is requested in the same cycle; fptr=target word+1, infl=1, drop_lo=redirect_pc[1].
- Stall:
  - Outputs remain stable.
  - Arriving data is still pushed.
  - Requests obey the rule with pop=0.

Decomposition:
- Shared package fetch_pkg holds:
  - PC_W.
  - Queue depth constant QDEPTH=4.
  - Function is_compressed(hw) = hw[1:0]!=2'b11.
  - Reset PC constant.
- One natural sub-module: fetch_hw_queue.
  - 4×16 shift queue.
  - push of 0/1/2 halfwords, pop of 0/1/2 halfwords in the same cycle.
  - Exposes q[0], q[1], cnt.
- The top level owns pc/fptr/infl/drop_lo and the request rule.

Test Plan:
- Reset then release, word0=0x00A00093 -> cycle 2: if_valid=1, if_inst=0x00A00093, if_PC=0x000, if_pc4=0x004, if_is_c=0.
- word1=0x45054501 after word0 -> consecutive cycles emit 0x00004501 (PC 0x004, pc4 0x006, is_c=1) then 0x00004505 (PC 0x006, pc4 0x008); no bubble.
- Straddle: word2=0x00934585, word3=0x000100A0 -> emit 0x00004585 @0x008, then 0x00A00093 @0x00A with pc4=0x00E, then 0x00000001 @0x00E.
- id_stall held 3 cycles mid-stream -> outputs unchanged for 3 cycles, cnt<=4, sequence resumes with no loss or duplication.
- redirect with redirect_pc=0x012 during id_stall -> imem_addr=0x004 that cycle; 2 cycles later if_PC=0x012 with the upper half of word 4; stale queue contents never appear.
- Async rst pulse mid-cycle while infl=1 -> outputs 0 immediately; after release, fetch restarts at RESET_PC and the stale return is ignored.
